// File: rtl/tlb_op_ctrl_pkg.sv
// Shared constants for the CP0 TLB instruction sequencer: op codes, CP0
// register field positions, update-mask bits and the FSM state encoding.
package tlb_pkg;

  localparam logic [1:0] OP_TLBP  = 2'd0;
  localparam logic [1:0] OP_TLBR  = 2'd1;
  localparam logic [1:0] OP_TLBWI = 2'd2;
  localparam logic [1:0] OP_TLBWR = 2'd3;

  localparam int HI_VPN2_MSB = 31;
  localparam int HI_VPN2_LSB = 13;
  localparam int HI_ASID_MSB = 7;
  localparam int HI_ASID_LSB = 0;

  localparam int LO_PFN_MSB = 25;
  localparam int LO_PFN_LSB = 6;
  localparam int LO_C_MSB   = 5;
  localparam int LO_C_LSB   = 3;
  localparam int LO_D       = 2;
  localparam int LO_V       = 1;
  localparam int LO_G       = 0;

  localparam int UPD_INDEX   = 0;
  localparam int UPD_ENTRYHI = 1;
  localparam int UPD_ENTRYLO = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // EntryLo carries the entry-wide G bit in every half.
  function automatic logic [31:0] pack_entrylo(input logic [19:0] pfn, input logic [2:0] c,
                                               input logic d, input logic v, input logic g);
    return {6'b0, pfn, c, d, v, g};
  endfunction

endpackage

// File: rtl/tlb_op_ctrl_if.sv
// CP0-stage side of the TLB op sequencer: op request handshake with the
// CP0 register snapshot, and the register-update / refetch response.
interface tlb_op_ctrl_if;
  logic        op_valid;
  logic        op_ready;
  logic [1:0]  op_code;
  logic [31:0] cp0_entryhi;
  logic [31:0] cp0_entrylo0;
  logic [31:0] cp0_entrylo1;
  logic [31:0] cp0_index;
  logic        upd_valid;
  logic [2:0]  upd_mask;
  logic [31:0] upd_index;
  logic [31:0] upd_entryhi;
  logic [31:0] upd_entrylo0;
  logic [31:0] upd_entrylo1;
  logic        refetch;

  modport master (
    output op_valid, op_code, cp0_entryhi, cp0_entrylo0, cp0_entrylo1, cp0_index,
    input  op_ready, upd_valid, upd_mask, upd_index, upd_entryhi, upd_entrylo0,
           upd_entrylo1, refetch
  );

  modport slave (
    input  op_valid, op_code, cp0_entryhi, cp0_entrylo0, cp0_entrylo1, cp0_index,
    output op_ready, upd_valid, upd_mask, upd_index, upd_entryhi, upd_entrylo0,
           upd_entrylo1, refetch
  );
endinterface

// File: rtl/tlb_op_ctrl_random.sv
// CP0 Random register: free-running down-counter that wraps from 0 back to
// the top TLB entry, used as the victim index for TLBWR.
module tlb_random #(
  parameter  int TLBNUM = 16,
  localparam int IW     = $clog2(TLBNUM)
) (
  input  logic          clk,
  input  logic          resetn,
  output logic [IW-1:0] random
);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)              random <= IW'(TLBNUM - 1);
    else if (random == '0)    random <= IW'(TLBNUM - 1);
    else                      random <= random - IW'(1);
  end

endmodule

// File: rtl/tlb_op_ctrl.sv
// Sequencer for TLBP/TLBR/TLBWI/TLBWR: snapshots the CP0 registers, performs
// one TLB access, then returns CP0 register updates or a refetch pulse.
module tlb_op_ctrl
  import tlb_pkg::*;
#(
  parameter  int TLBNUM = 16,
  localparam int IW     = $clog2(TLBNUM)
) (
  input  logic          clk,
  input  logic          resetn,
  tlb_op_ctrl_if.slave  cp0,
  output logic [IW-1:0] random,
  output logic [18:0]   tlb_s1_vpn2,
  output logic          tlb_s1_odd_page,
  output logic [7:0]    tlb_s1_asid,
  input  logic          tlb_s1_found,
  input  logic [IW-1:0] tlb_s1_index,
  output logic [IW-1:0] tlb_r_index,
  input  logic [18:0]   tlb_r_vpn2,
  input  logic [7:0]    tlb_r_asid,
  input  logic          tlb_r_g,
  input  logic [19:0]   tlb_r_pfn0,
  input  logic [2:0]    tlb_r_c0,
  input  logic          tlb_r_d0,
  input  logic          tlb_r_v0,
  input  logic [19:0]   tlb_r_pfn1,
  input  logic [2:0]    tlb_r_c1,
  input  logic          tlb_r_d1,
  input  logic          tlb_r_v1,
  output logic          tlb_we,
  output logic [IW-1:0] tlb_w_index,
  output logic [18:0]   tlb_w_vpn2,
  output logic [7:0]    tlb_w_asid,
  output logic          tlb_w_g,
  output logic [19:0]   tlb_w_pfn0,
  output logic [2:0]    tlb_w_c0,
  output logic          tlb_w_d0,
  output logic          tlb_w_v0,
  output logic [19:0]   tlb_w_pfn1,
  output logic [2:0]    tlb_w_c1,
  output logic          tlb_w_d1,
  output logic          tlb_w_v1
);

  state_t          state, state_nxt;
  logic            accept;
  logic [1:0]      op_q;
  logic [18:0]     vpn2_q;
  logic [7:0]      asid_q;
  logic [25:0]     lo0_q, lo1_q;
  logic [IW-1:0]   idx_q, wr_rand;
  logic [31:0]     probe_q, rd_hi_q, rd_lo0_q, rd_lo1_q;

  tlb_random #(.TLBNUM(TLBNUM)) u_random (
    .clk    (clk),
    .resetn (resetn),
    .random (random)
  );

  assign accept = cp0.op_valid && (state == ST_IDLE);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = ST_EXEC;
      ST_EXEC: state_nxt = ST_RESP;
      ST_RESP: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Snapshot at acceptance so the TLB ports never see the live CP0 values;
  // Random keeps running, so TLBWR uses the value seen at acceptance.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      op_q     <= OP_TLBP;
      vpn2_q   <= '0;
      asid_q   <= '0;
      lo0_q    <= '0;
      lo1_q    <= '0;
      idx_q    <= '0;
      wr_rand  <= '0;
      probe_q  <= '0;
      rd_hi_q  <= '0;
      rd_lo0_q <= '0;
      rd_lo1_q <= '0;
    end else begin
      if (accept) begin
        op_q    <= cp0.op_code;
        vpn2_q  <= cp0.cp0_entryhi[HI_VPN2_MSB:HI_VPN2_LSB];
        asid_q  <= cp0.cp0_entryhi[HI_ASID_MSB:HI_ASID_LSB];
        lo0_q   <= cp0.cp0_entrylo0[LO_PFN_MSB:0];
        lo1_q   <= cp0.cp0_entrylo1[LO_PFN_MSB:0];
        idx_q   <= cp0.cp0_index[IW-1:0];
        wr_rand <= random;
      end
      if (state == ST_EXEC && op_q == OP_TLBP)
        probe_q <= tlb_s1_found ? {{(32-IW){1'b0}}, tlb_s1_index} : 32'h8000_0000;
      if (state == ST_EXEC && op_q == OP_TLBR) begin
        rd_hi_q  <= {tlb_r_vpn2, 5'b0, tlb_r_asid};
        rd_lo0_q <= pack_entrylo(tlb_r_pfn0, tlb_r_c0, tlb_r_d0, tlb_r_v0, tlb_r_g);
        rd_lo1_q <= pack_entrylo(tlb_r_pfn1, tlb_r_c1, tlb_r_d1, tlb_r_v1, tlb_r_g);
      end
    end
  end

  always_comb begin
    cp0.op_ready     = (state == ST_IDLE);
    cp0.upd_valid    = (state == ST_RESP);
    cp0.upd_mask     = '0;
    cp0.upd_index    = '0;
    cp0.upd_entryhi  = '0;
    cp0.upd_entrylo0 = '0;
    cp0.upd_entrylo1 = '0;
    cp0.refetch      = 1'b0;
    tlb_we           = (state == ST_EXEC) && (op_q == OP_TLBWI || op_q == OP_TLBWR);
    if (state == ST_RESP) begin
      case (op_q)
        OP_TLBP: begin
          cp0.upd_mask[UPD_INDEX] = 1'b1;
          cp0.upd_index           = probe_q;
        end
        OP_TLBR: begin
          cp0.upd_mask[UPD_ENTRYHI] = 1'b1;
          cp0.upd_mask[UPD_ENTRYLO] = 1'b1;
          cp0.upd_entryhi           = rd_hi_q;
          cp0.upd_entrylo0          = rd_lo0_q;
          cp0.upd_entrylo1          = rd_lo1_q;
        end
        default: cp0.refetch = 1'b1;
      endcase
    end
  end

  assign tlb_s1_vpn2     = vpn2_q;
  assign tlb_s1_asid     = asid_q;
  assign tlb_s1_odd_page = 1'b0;
  assign tlb_r_index     = idx_q;

  assign tlb_w_index = (op_q == OP_TLBWR) ? wr_rand : idx_q;
  assign tlb_w_vpn2  = vpn2_q;
  assign tlb_w_asid  = asid_q;
  assign tlb_w_g     = lo0_q[LO_G] & lo1_q[LO_G];
  assign tlb_w_pfn0  = lo0_q[LO_PFN_MSB:LO_PFN_LSB];
  assign tlb_w_c0    = lo0_q[LO_C_MSB:LO_C_LSB];
  assign tlb_w_d0    = lo0_q[LO_D];
  assign tlb_w_v0    = lo0_q[LO_V];
  assign tlb_w_pfn1  = lo1_q[LO_PFN_MSB:LO_PFN_LSB];
  assign tlb_w_c1    = lo1_q[LO_C_MSB:LO_C_LSB];
  assign tlb_w_d1    = lo1_q[LO_D];
  assign tlb_w_v1    = lo1_q[LO_V];

endmodule
